// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: fetch-stage state type and shared constants (rev 1.0).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // ARM MOV r0,r0 used as the pipeline bubble
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'hE1A00000;
  localparam int unsigned PC_INC            = 4;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if_id_reg.sv
`default_nettype none
// if_id_reg: IF/ID pipeline register; flush beats load beats hold (rev 1.0).
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter int                 INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// instruction_fetch_unit: IF stage with req/ack imem port, hold buffer and
// post-branch stale-response discard, feeding the IF/ID register (rev 1.0).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchAddr,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic [ADDR_W-1:0]  pc_ID,
  output logic [INSTR_W-1:0] instruction_ID,
  output logic               valid_ID
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_e       state_q,     state_d;
  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic [ADDR_W-1:0]  req_addr_q,  req_addr_d;
  logic [ADDR_W-1:0]  buf_pc_q,    buf_pc_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;

  logic               ifid_flush;
  logic               ifid_load;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  req_next;

  assign imemReq  = (state_q == FETCH) || (state_q == DROP);
  assign imemAddr = req_addr_q;
  assign req_next = req_addr_q + PC_STEP;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    ifid_flush  = 1'b0;
    ifid_load   = 1'b0;
    ifid_pc     = req_next;
    ifid_instr  = imemData;

    if (branchTaken) begin
      pc_d       = branchAddr;
      ifid_flush = 1'b1;
      // An unanswered request must still complete on the bus; its data is dropped.
      if (imemReq && !imemAck) begin
        state_d = DROP;
      end else begin
        req_addr_d = branchAddr;
        state_d    = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
        FETCH: begin
          if (imemAck) begin
            pc_d = req_next;
            if (freeze) begin
              buf_pc_d    = req_next;
              buf_instr_d = imemData;
              state_d     = HOLD;
            end else begin
              ifid_load  = 1'b1;
              req_addr_d = req_next;
            end
          end else if (!freeze) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            ifid_load  = 1'b1;
            ifid_pc    = buf_pc_q;
            ifid_instr = buf_instr_q;
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        DROP: begin
          ifid_flush = !freeze;
          if (imemAck) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_pc_q    <= '0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  if_id_reg #(
    .ADDR_W      (ADDR_W),
    .INSTR_W     (INSTR_W),
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .flush_i(ifid_flush),
    .load_i (ifid_load),
    .pc_i   (ifid_pc),
    .instr_i(ifid_instr),
    .pc_o   (pc_ID),
    .instr_o(instruction_ID),
    .valid_o(valid_ID)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit: directed scenarios plus a randomized run checked
// against a program-order stream model and an imem-latency memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = 32'h0;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] pc_ID;
  logic [31:0] instruction_ID;
  logic        valid_ID;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;   // wait cycles before ack (0 = same cycle as req)
  int req_age = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branchTaken   (branchTaken),
    .branchAddr    (branchAddr),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemAck       (imemAck),
    .imemData      (imemData),
    .pc_ID         (pc_ID),
    .instruction_ID(instruction_ID),
    .valid_ID      (valid_ID)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h3C5A_0001;
  endfunction

  task automatic drive_mem();
    imemAck  = imemReq && (req_age >= mem_lat);
    imemData = imemAck ? mem_data(imemAddr) : 32'h0;
  endtask

  task automatic tick();
    logic hs, rq;
    hs = imemReq && imemAck;
    rq = imemReq;
    @(posedge clk);
    #1;
    if (hs || !rq) req_age = 0;
    else           req_age++;
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = 32'h0;
    imemAck = 1'b0; imemData = 32'h0; mem_lat = 0; req_age = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Zero-wait fetches from reset until pc_ID = 4*n (request for 4*n pending).
  task automatic run_to(input int n);
    mem_lat = 0;
    drive_mem(); tick();
    for (int i = 0; i < n; i++) begin
      drive_mem(); tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imemReq); end
    checks++; if (pc_ID !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_ID); end
    checks++; if (instruction_ID !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instruction_ID, NOP); end
    checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_ID); end
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %0b want 0", imemReq); end
    tick();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    drive_mem(); tick();
    checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL zw_first_edge_valid: got %0b want 0", valid_ID); end
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      drive_mem();
      checks++; if (imemReq !== 1'b1 || imemAddr !== a) begin errors++; $display("FAIL zw_addr[%0d]: got req=%0b addr=%h want 1/%h", i, imemReq, imemAddr, a); end
      tick();
      checks++; if (valid_ID !== 1'b1 || pc_ID !== a + 32'd4 || instruction_ID !== mem_data(a)) begin
        errors++; $display("FAIL zw_id[%0d]: got v=%0b pc=%h ins=%h want 1/%h/%h", i, valid_ID, pc_ID, instruction_ID, a + 32'd4, mem_data(a)); end
    end
  endtask

  task automatic test_latency2();
    logic [31:0] a;
    do_reset();
    mem_lat = 1;
    drive_mem(); tick();
    for (int c = 1; c <= 8; c++) begin
      a = 32'(4 * ((c - 1) / 2));
      drive_mem();
      checks++; if (imemReq !== 1'b1 || imemAddr !== a) begin errors++; $display("FAIL lat2_addr[%0d]: got req=%0b addr=%h want 1/%h", c, imemReq, imemAddr, a); end
      tick();
      if (c % 2 == 0) begin
        checks++; if (valid_ID !== 1'b1 || pc_ID !== a + 32'd4 || instruction_ID !== mem_data(a)) begin
          errors++; $display("FAIL lat2_id[%0d]: got v=%0b pc=%h ins=%h want 1/%h/%h", c, valid_ID, pc_ID, instruction_ID, a + 32'd4, mem_data(a)); end
      end else begin
        checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin
          errors++; $display("FAIL lat2_bubble[%0d]: got v=%0b ins=%h want 0/%h", c, valid_ID, instruction_ID, NOP); end
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    run_to(4);
    freeze = 1'b1;
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin errors++; $display("FAIL frz_req: got req=%0b addr=%h want 1/10", imemReq, imemAddr); end
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++; if (imemReq !== 1'b0 || pc_ID !== 32'h10 || valid_ID !== 1'b1 || instruction_ID !== mem_data(32'h0C)) begin
        errors++; $display("FAIL frz_hold[%0d]: got req=%0b pc=%h v=%0b ins=%h want 0/10/1/%h", j, imemReq, pc_ID, valid_ID, instruction_ID, mem_data(32'h0C)); end
      if (j < 2) begin drive_mem(); tick(); end
    end
    freeze = 1'b0;
    drive_mem(); tick();
    checks++; if (pc_ID !== 32'h14 || valid_ID !== 1'b1 || instruction_ID !== mem_data(32'h10)) begin
      errors++; $display("FAIL frz_release: got pc=%h v=%0b ins=%h want 14/1/%h", pc_ID, valid_ID, instruction_ID, mem_data(32'h10)); end
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) begin errors++; $display("FAIL frz_resume: got req=%0b addr=%h want 1/14", imemReq, imemAddr); end
    tick();
    checks++; if (pc_ID !== 32'h18 || valid_ID !== 1'b1) begin errors++; $display("FAIL frz_next: got pc=%h v=%0b want 18/1", pc_ID, valid_ID); end
  endtask

  task automatic test_branch_pending();
    do_reset();
    run_to(8);
    mem_lat = 2;
    freeze = 1'b1; branchTaken = 1'b1; branchAddr = 32'h100;
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin errors++; $display("FAIL brp_req: got req=%0b addr=%h want 1/20", imemReq, imemAddr); end
    tick();
    branchTaken = 1'b0;
    checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin errors++; $display("FAIL brp_flush: got v=%0b ins=%h want 0/%h", valid_ID, instruction_ID, NOP); end
    for (int k = 0; k < 2; k++) begin
      drive_mem();
      checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin errors++; $display("FAIL brp_stale_addr[%0d]: got req=%0b addr=%h want 1/20", k, imemReq, imemAddr); end
      tick();
      checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin errors++; $display("FAIL brp_drop[%0d]: got v=%0b ins=%h want 0/%h", k, valid_ID, instruction_ID, NOP); end
    end
    freeze = 1'b0; mem_lat = 0;
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin errors++; $display("FAIL brp_target: got req=%0b addr=%h want 1/100", imemReq, imemAddr); end
    tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'h104 || instruction_ID !== mem_data(32'h100)) begin
      errors++; $display("FAIL brp_id: got v=%0b pc=%h ins=%h want 1/104/%h", valid_ID, pc_ID, instruction_ID, mem_data(32'h100)); end
  endtask

  task automatic test_branch_ack();
    logic [31:0] ba;
    do_reset();
    run_to(16);
    ba = ($urandom & 32'h0000_FFF0) | 32'h0001_0000;
    branchTaken = 1'b1; branchAddr = ba;
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin errors++; $display("FAIL bra_req: got req=%0b addr=%h want 1/40", imemReq, imemAddr); end
    tick();
    branchTaken = 1'b0;
    checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin errors++; $display("FAIL bra_flush: got v=%0b ins=%h want 0/%h", valid_ID, instruction_ID, NOP); end
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== ba) begin errors++; $display("FAIL bra_target: got req=%0b addr=%h want 1/%h", imemReq, imemAddr, ba); end
    tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== ba + 32'd4 || instruction_ID !== mem_data(ba)) begin
      errors++; $display("FAIL bra_id: got v=%0b pc=%h ins=%h want 1/%h/%h", valid_ID, pc_ID, instruction_ID, ba + 32'd4, mem_data(ba)); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_mem(); tick();
    branchTaken = 1'b1; branchAddr = 32'hFFFF_FFF8;
    drive_mem(); tick();
    branchTaken = 1'b0;
    drive_mem(); tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a: got v=%0b pc=%h want 1/fffffffc", valid_ID, pc_ID); end
    drive_mem(); tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'h0 || instruction_ID !== mem_data(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_b: got v=%0b pc=%h ins=%h want 1/0/%h", valid_ID, pc_ID, instruction_ID, mem_data(32'hFFFF_FFFC)); end
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(3);
    mem_lat = 1; freeze = 1'b1;
    drive_mem(); tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'h0C) begin errors++; $display("FAIL rmid_pre: got v=%0b pc=%h want 1/c", valid_ID, pc_ID); end
    rst = 1'b0;
    #1;
    checks++; if (imemReq !== 1'b0 || pc_ID !== 32'h0 || valid_ID !== 1'b0 || instruction_ID !== NOP) begin
      errors++; $display("FAIL rmid_async: got req=%0b pc=%h v=%0b ins=%h want 0/0/0/%h", imemReq, pc_ID, valid_ID, instruction_ID, NOP); end
    imemAck = 1'b1; imemData = mem_data(32'h0C);
    @(posedge clk); #1;
    rst = 1'b1; freeze = 1'b0;
    checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL rmid_idle: got req=%0b want 0", imemReq); end
    @(posedge clk); #1;
    req_age = 0; mem_lat = 0;
    checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin errors++; $display("FAIL rmid_stray: got v=%0b ins=%h want 0/%h", valid_ID, instruction_ID, NOP); end
    drive_mem();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("FAIL rmid_restart: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
    tick();
    checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'h4 || instruction_ID !== mem_data(32'h0)) begin
      errors++; $display("FAIL rmid_id: got v=%0b pc=%h ins=%h want 1/4/%h", valid_ID, pc_ID, instruction_ID, mem_data(32'h0)); end
  endtask

  // Stream model: delivered pc_ID values follow program order from reset or
  // from the latest branch target; freeze holds IF/ID; branch flushes it.
  task automatic test_random();
    logic [31:0] exp_pc, p_addr, p_pc, p_in, p_ba;
    logic        p_req, p_ack, p_v, p_fr, p_br;
    int          delivered;
    do_reset();
    exp_pc = 32'h4;
    delivered = 0;
    mem_lat = $urandom_range(0, 3);
    for (int n = 0; n < 3000; n++) begin
      freeze      = ($urandom_range(0, 3) == 0);
      branchTaken = ($urandom_range(0, 15) == 0);
      branchAddr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      drive_mem();
      p_req = imemReq; p_ack = imemAck; p_addr = imemAddr;
      p_pc = pc_ID; p_in = instruction_ID; p_v = valid_ID;
      p_fr = freeze; p_br = branchTaken; p_ba = branchAddr;
      tick();
      if (req_age == 0) mem_lat = $urandom_range(0, 3);
      if (p_req && !p_ack) begin
        checks++; if (imemReq !== 1'b1 || imemAddr !== p_addr) begin errors++; $display("FAIL rnd_stable[%0d]: got req=%0b addr=%h want 1/%h", n, imemReq, imemAddr, p_addr); end
      end
      if (p_br) begin
        checks++; if (valid_ID !== 1'b0 || instruction_ID !== NOP) begin errors++; $display("FAIL rnd_flush[%0d]: got v=%0b ins=%h want 0/%h", n, valid_ID, instruction_ID, NOP); end
        exp_pc = p_ba + 32'd4;
      end else if (p_fr) begin
        checks++; if (pc_ID !== p_pc || instruction_ID !== p_in || valid_ID !== p_v) begin
          errors++; $display("FAIL rnd_freeze[%0d]: got %h/%h/%0b want %h/%h/%0b", n, pc_ID, instruction_ID, valid_ID, p_pc, p_in, p_v); end
      end else if (valid_ID === 1'b1) begin
        checks++; if (pc_ID !== exp_pc || instruction_ID !== mem_data(pc_ID - 32'd4)) begin
          errors++; $display("FAIL rnd_stream[%0d]: got pc=%h ins=%h want %h/%h", n, pc_ID, instruction_ID, exp_pc, mem_data(exp_pc - 32'd4)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        checks++; if (instruction_ID !== NOP) begin errors++; $display("FAIL rnd_bubble[%0d]: got ins=%h want %h", n, instruction_ID, NOP); end
      end
    end
    checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d instructions want >= 100", delivered); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency2();
    test_freeze();
    test_branch_pending();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage ARM core; the ID stage consumes its outputs.
- Honours `freeze` from the hazard unit and `branchTaken`/`branchAddr` from EXE.
- Fetches over a variable-latency req/ack instruction-memory port, with a one-entry hold buffer and stale-response discard after a branch.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- NOP_INSTR, 32'hE1A00000, bubble instruction (MOV r0,r0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  hazard-unit stall; hold IF/ID
- branchTaken  in  1  EXE branch resolved taken; flush
- branchAddr  in  ADDR_W  branch target
- imemReq  out  1  instruction request valid
- imemAddr  out  ADDR_W  request address; stable while imemReq && !imemAck
- imemAck  in  1  response valid this cycle; may arrive in the same cycle as imemReq
- imemData  in  INSTR_W  instruction, valid when imemAck
- pc_ID  out  ADDR_W  fetched address + 4
- instruction_ID  out  INSTR_W  instruction to ID
- valid_ID  out  1  instruction_ID is real (0 = bubble)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, reqAddr=RESET_PC.
  - pc_ID=0, instruction_ID=NOP_INSTR, valid_ID=0, imemReq=0.
- States and imemReq:
  - States: IDLE, FETCH, HOLD, DROP.
  - imemReq=1 in FETCH and DROP only.
  - imemAddr = reqAddr register.
- IDLE: next cycle -> FETCH; reqAddr=pc.
- FETCH, no ack:
  - freeze=0: IF/ID <= bubble (NOP_INSTR, valid 0).
  - freeze=1: IF/ID holds.
- FETCH, ack, freeze=0:
  - IF/ID <= {reqAddr+4, imemData, 1}; pc=reqAddr+4; reqAddr=reqAddr+4.
  - Stay in FETCH. Back-to-back acks give one instruction per cycle.
- FETCH, ack, freeze=1:
  - imemData -> hold buffer {reqAddr+4, imemData}; pc=reqAddr+4.
  - IF/ID holds; -> HOLD.
- HOLD:
  - freeze=1: everything holds; imemReq=0.
  - freeze=0: IF/ID <= buffer, valid 1; reqAddr=pc; -> FETCH.
- DROP (branch with request outstanding):
  - imemAddr stays at the stale address until ack; the ack's data is discarded.
  - Then reqAddr=pc; -> FETCH.
  - Freeze does not affect DROP. While in DROP, IF/ID holds if freeze, else bubble.
- branchTaken has top priority over freeze in every state:
  - pc=branchAddr; IF/ID <= bubble (flush, even if freeze=1); hold buffer invalidated.
  - If imemReq && !imemAck this cycle: -> DROP (reqAddr unchanged).
  - Otherwise: reqAddr=branchAddr; -> FETCH. This covers an ack in the same cycle, whose data is discarded.
  - In DROP: pc updates; stay in DROP.
- Address arithmetic: PC increment is +4 modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0.
- No instruction is duplicated or lost. Sequence seen at ID (valid_ID=1 cycles, pc_ID order) equals the program order of the fetched stream.
- Reset mid-request: state returns to IDLE; a later stray imemAck is ignored (imemReq=0 in IDLE).

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, FETCH, HOLD, DROP}
  - NOP_INSTR constant
  - PC_INC = 4
- Sub-module if_id_reg:
  - Pipeline register {pc, instruction, valid} with load/flush/hold controls.
  - Flush beats hold; reset to bubble.
  - Instantiated once.
- Remaining FSM, PC and hold buffer sit in the top module.

Test Plan:
1. Reset then zero-wait memory (ack same cycle as req), freeze=0: imemAddr 0,4,8; ID sees pc_ID 4,8,12, valid_ID=1 every cycle from the 2nd post-reset edge.
2. 2-cycle-latency memory: each instruction followed by a bubble (valid_ID=0, instruction_ID=E1A00000); no address repeats.
3. Freeze for 3 cycles while an ack for addr 0x10 arrives:
   - state HOLD, imemReq=0, IF/ID holds the 0x0C entry.
   - After freeze drops: pc_ID=0x14, then fetch resumes at 0x14.
4. branchTaken, branchAddr=0x100, while request 0x20 is pending with freeze=1:
   - IF/ID flushed; imemAddr stays 0x20 until ack; that data is dropped.
   - Next request is 0x100; pc_ID=0x104.
5. Branch in the same cycle as ack for 0x40: data discarded; next imemAddr=branchAddr; no 0x40 instruction appears at ID.
6. rst=0 asserted mid-request with ack arriving 1 cycle later:
   - All outputs return to reset values immediately.
   - Stale ack ignored; fetch restarts at RESET_PC.
